// File: rtl/nn_sequencer.sv
// nn_sequencer: sequences forward and backward passes through a layered network, one neuron per phase step.
module nn_sequencer #(
    parameter int DEPTH   = 3,
    parameter int NEURONS = 4,
    parameter int IDX_W   = 8,
    parameter int LR_W    = 4,
    parameter int PASS_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              train,
    input  logic              stall,
    input  logic [LR_W-1:0]   lr_shift,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_layer,
    input  logic [IDX_W-1:0]  cfg_count,
    output logic              busy,
    output logic              valid,
    output logic [IDX_W-1:0]  layer_idx,
    output logic [IDX_W-1:0]  neuron_idx,
    output logic              w_rd,
    output logic              y_we,
    output logic              d_gen,
    output logic              dw_gen,
    output logic              d_we,
    output logic              w_we,
    output logic [LR_W-1:0]   learning_rate,
    output logic [PASS_W-1:0] pass_count
);
    typedef enum logic [3:0] {
        IDLE, FWD_RD, FWD_WR, FWD_NEXT, BWD_DGEN, BWD_DW, BWD_WUPD, BWD_PREV, DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] layer, neuron, cnt_up, cnt_cur, cfg_val;
    logic [IDX_W-1:0] cnt [DEPTH];
    logic             train_q, hold, cfg_ok, run;
    logic [LR_W-1:0]  lr_q;

    assign hold    = stall && (state inside {FWD_RD, FWD_WR, FWD_NEXT, BWD_DGEN, BWD_DW,
                                             BWD_WUPD, BWD_PREV, DONE});
    assign run     = !stall;
    assign cfg_ok  = cfg_we && state == IDLE && cfg_layer < IDX_W'(DEPTH);
    assign cfg_val = cfg_count == '0 ? IDX_W'(1) :
                     cfg_count > IDX_W'(NEURONS) ? IDX_W'(NEURONS) : cfg_count;

    // Forward steps walk the layer being produced; backward steps walk the current layer.
    always_comb begin
        cnt_up  = '0;
        cnt_cur = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (IDX_W'(i) == layer + IDX_W'(1)) cnt_up = cnt[i];
            if (IDX_W'(i) == layer) cnt_cur = cnt[i];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            layer      <= '0;
            neuron     <= '0;
            pass_count <= '0;
            train_q    <= 1'b0;
            lr_q       <= '0;
            for (int i = 0; i < DEPTH; i++) cnt[i] <= IDX_W'(NEURONS);
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (cfg_ok && IDX_W'(i) == cfg_layer) cnt[i] <= cfg_val;
            if (!hold) begin
                case (state)
                    IDLE: if (start) begin
                        state   <= FWD_RD;
                        layer   <= '0;
                        neuron  <= '0;
                        train_q <= train;
                        lr_q    <= lr_shift;
                    end
                    FWD_RD: state <= FWD_WR;
                    FWD_WR: if (neuron == cnt_up - IDX_W'(1)) state <= FWD_NEXT;
                    else begin
                        neuron <= neuron + IDX_W'(1);
                        state  <= FWD_RD;
                    end
                    FWD_NEXT: begin
                        neuron <= '0;
                        if (layer < IDX_W'(DEPTH - 2)) begin
                            layer <= layer + IDX_W'(1);
                            state <= FWD_RD;
                        end else if (train_q) begin
                            layer <= IDX_W'(DEPTH - 1);
                            state <= BWD_DGEN;
                        end else state <= DONE;
                    end
                    BWD_DGEN: state <= BWD_DW;
                    BWD_DW:   state <= BWD_WUPD;
                    BWD_WUPD: if (neuron == cnt_cur - IDX_W'(1)) state <= BWD_PREV;
                    else begin
                        neuron <= neuron + IDX_W'(1);
                        state  <= BWD_DGEN;
                    end
                    BWD_PREV: begin
                        neuron <= '0;
                        if (layer == IDX_W'(1)) state <= DONE;
                        else begin
                            layer <= layer - IDX_W'(1);
                            state <= BWD_DGEN;
                        end
                    end
                    DONE: begin
                        pass_count <= pass_count + PASS_W'(1);
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy          = state != IDLE;
    assign valid         = run && state == DONE;
    assign w_rd          = run && state == FWD_RD;
    assign y_we          = run && state == FWD_WR;
    assign d_gen         = run && state == BWD_DGEN;
    assign dw_gen        = run && state == BWD_DW;
    assign d_we          = run && state == BWD_DW;
    assign w_we          = run && state == BWD_WUPD;
    assign learning_rate = state == BWD_DW ? lr_q : '0;
    assign layer_idx     = state inside {FWD_RD, FWD_WR} ? layer + IDX_W'(1) :
                           state inside {BWD_DGEN, BWD_DW} ? layer :
                           state == BWD_WUPD ? layer - IDX_W'(1) : '0;
    assign neuron_idx    = state inside {FWD_RD, FWD_WR, BWD_DGEN, BWD_DW, BWD_WUPD} ? neuron : '0;
endmodule

// File: tb/tb_nn_sequencer.sv
// tb_nn_sequencer: directed passes with hand-computed busy lengths and strobe orders.
module tb_nn_sequencer;
    localparam int PW = 4;

    logic          CLK = 0, RST = 1;
    logic          start = 0, train = 0, stall = 0, cfg_we = 0;
    logic [3:0]    lr_shift = 0;
    logic [7:0]    cfg_layer = 0, cfg_count = 0;
    logic          busy, valid, w_rd, y_we, d_gen, dw_gen, d_we, w_we;
    logic [7:0]    layer_idx, neuron_idx;
    logic [3:0]    learning_rate;
    logic [PW-1:0] pass_count;

    int total = 0, bad = 0;
    int busy_n, valid_n, lr_n, lr_bad, multi, split;
    logic [7:0] ywq[$], wwq[$];
    logic [7:0] y_exp[5] = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21};
    logic [7:0] w_exp[5] = '{8'h10, 8'h11, 8'h00, 8'h01, 8'h02};

    nn_sequencer #(.PASS_W(PW)) dut (
        .CLK(CLK), .RST(RST), .start(start), .train(train), .stall(stall),
        .lr_shift(lr_shift), .cfg_we(cfg_we), .cfg_layer(cfg_layer), .cfg_count(cfg_count),
        .busy(busy), .valid(valid), .layer_idx(layer_idx), .neuron_idx(neuron_idx),
        .w_rd(w_rd), .y_we(y_we), .d_gen(d_gen), .dw_gen(dw_gen), .d_we(d_we), .w_we(w_we),
        .learning_rate(learning_rate), .pass_count(pass_count)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        #3;
        busy_n  += int'(busy);
        valid_n += int'(valid);
        if (y_we) ywq.push_back({layer_idx[3:0], neuron_idx[3:0]});
        if (w_we) wwq.push_back({layer_idx[3:0], neuron_idx[3:0]});
        if (learning_rate != 0) begin
            lr_n++;
            if (!dw_gen || learning_rate != 4'd3) lr_bad++;
        end
        if ($countones({w_rd, y_we, d_gen, dw_gen | d_we, w_we}) > 1) multi++;
        if (d_we != dw_gen) split++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        busy_n = 0; valid_n = 0; lr_n = 0; lr_bad = 0; multi = 0; split = 0;
        ywq.delete(); wwq.delete();
    endtask

    task automatic cfg(input logic [7:0] l, input logic [7:0] c);
        @(negedge CLK); cfg_we = 1; cfg_layer = l; cfg_count = c;
        @(negedge CLK); cfg_we = 0;
    endtask

    task automatic run_pass(input logic tr, input logic [3:0] lr, input int stall_len, input logic busy_cfg);
        clear_mon();
        @(negedge CLK); start = 1; train = tr; lr_shift = lr;
        @(negedge CLK); start = 0; train = 0; lr_shift = 0;
        if (busy_cfg) begin cfg_we = 1; cfg_layer = 1; cfg_count = 1; end
        for (int c = 0; c < 300 && busy; c++) begin
            if (stall_len > 0 && y_we) begin
                stall = 1;
                repeat (stall_len) @(negedge CLK);
                stall = 0;
                stall_len = 0;
            end else @(negedge CLK);
        end
        cfg_we = 0;
        check("timeout", 32'(busy), 0);
        @(negedge CLK);
    endtask

    task automatic check_y(input string tag);
        check({tag, "_ycnt"}, ywq.size(), 5);
        for (int i = 0; i < 5 && i < ywq.size(); i++) check({tag, "_y"}, ywq[i], y_exp[i]);
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        RST = 0;
        check("rst_busy", 32'(busy), 0);
        check("rst_strobes", 32'({valid, w_rd, y_we, d_gen, dw_gen, d_we, w_we}), 0);
        check("rst_idx", {layer_idx, neuron_idx}, 0);
        check("rst_lr", 32'(learning_rate), 0);
        check("rst_pass", 32'(pass_count), 0);

        cfg(0, 4); cfg(1, 3); cfg(2, 2);
        run_pass(0, 0, 0, 0);
        check("inf_busy", busy_n, 13);
        check_y("inf");
        check("inf_valid", valid_n, 1);
        check("inf_pass", 32'(pass_count), 1);
        check("inf_wwe", wwq.size(), 0);
        check("idle_idx", {layer_idx, neuron_idx}, 0);

        run_pass(1, 3, 0, 0);
        check("trn_busy", busy_n, 30);
        check_y("trn");
        check("trn_wcnt", wwq.size(), 5);
        for (int i = 0; i < 5 && i < wwq.size(); i++) check("trn_w", wwq[i], w_exp[i]);
        check("trn_lr_n", lr_n, 5);
        check("trn_lr_bad", lr_bad, 0);
        check("trn_multi", multi, 0);
        check("trn_dwe", split, 0);
        check("trn_valid", valid_n, 1);
        check("trn_pass", 32'(pass_count), 2);

        run_pass(0, 0, 4, 0);
        check("stl_busy", busy_n, 17);
        check_y("stl");
        check("stl_valid", valid_n, 1);
        check("stl_pass", 32'(pass_count), 3);

        run_pass(0, 0, 0, 1);
        check("bcfg_busy", busy_n, 13);
        run_pass(0, 0, 0, 0);
        check("bcfg_after", busy_n, 13);

        cfg(1, 0); cfg(2, 2); cfg(3, 1);
        run_pass(0, 0, 0, 0);
        check("cnt0_busy", busy_n, 9);
        check("cnt0_ycnt", ywq.size(), 3);
        if (ywq.size() == 3) check("cnt0_y0", ywq[0], 8'h10);
        cfg(1, 3); cfg(2, 9);
        run_pass(0, 0, 0, 0);
        check("cnt9_busy", busy_n, 17);
        check("cnt9_ycnt", ywq.size(), 7);
        if (ywq.size() == 7) check("cnt9_ylast", ywq[6], 8'h23);

        clear_mon();
        @(negedge CLK); start = 1; train = 1; lr_shift = 3;
        @(negedge CLK); start = 0; train = 0; lr_shift = 0;
        for (int c = 0; c < 100 && !dw_gen; c++) @(negedge CLK);
        check("rst_mid_reach", 32'(dw_gen), 1);
        RST = 1;
        @(negedge CLK); RST = 0;
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_out", 32'({valid, w_rd, y_we, d_gen, dw_gen, d_we, w_we, learning_rate}), 0);
        check("rst_mid_idx", {layer_idx, neuron_idx}, 0);
        check("rst_mid_pass", 32'(pass_count), 0);
        repeat (3) @(negedge CLK);
        check("rst_mid_valid", valid_n, 0);
        run_pass(0, 0, 0, 0);
        check("rst_cnt_busy", busy_n, 19);
        check("rst_pass1", 32'(pass_count), 1);

        for (int p = 0; p < 14; p++) run_pass(0, 0, 0, 0);
        check("wrap_pre", 32'(pass_count), 15);
        run_pass(0, 0, 0, 0);
        check("wrap", 32'(pass_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nn_sequencer.md
NN_SEQUENCER -- requirements
Module: nn_sequencer

Interface
REQ-001 Parameter DEPTH, default 3: number of layers including the input layer; minimum 2.
REQ-002 Parameter NEURONS, default 4: maximum neurons per layer.
REQ-003 Parameter IDX_W, default 8: width of layer and neuron index outputs.
REQ-004 Parameter LR_W, default 4: width of learning-rate shift.
REQ-005 Parameter PASS_W, default 16: width of pass counter.
REQ-006 Ports:
- CLK  in  1  clock; one clock, all logic on rising edge.
- RST  in  1  reset; synchronous, active-high.
- start  in  1  request one pass; sampled only in IDLE.
- train  in  1  1 = forward plus backward pass; latched at accepted start.
- stall  in  1  freeze sequencing this cycle.
- lr_shift  in  LR_W  learning-rate divider; latched at accepted start.
- cfg_we  in  1  write layer neuron count.
- cfg_layer  in  IDX_W  layer written.
- cfg_count  in  IDX_W  neuron count written.
- busy  out  1  high in every non-IDLE state.
- valid  out  1  one-cycle pass-complete pulse.
- layer_idx  out  IDX_W  current layer.
- neuron_idx  out  IDX_W  current neuron.
- w_rd, y_we, d_gen, dw_gen, d_we, w_we  out  1 each  phase strobes.
- learning_rate  out  LR_W  latched lr_shift; nonzero only in BWD_DW.
- pass_count  out  PASS_W  completed passes.

Function
REQ-007 The count table SHALL hold DEPTH entries; cfg_count 0 is stored as 1 and values above NEURONS are stored as NEURONS.
REQ-008 cfg_we SHALL be ignored when busy=1 or when cfg_layer>=DEPTH.
REQ-009 States SHALL be IDLE, FWD_RD, FWD_WR, FWD_NEXT, BWD_DGEN, BWD_DW, BWD_WUPD, BWD_PREV, DONE.
REQ-010 IDLE SHALL move to FWD_RD on start=1, with layer=0 and neuron=0.
REQ-011 FWD_RD SHALL assert w_rd and move to FWD_WR.
REQ-012 FWD_WR SHALL assert y_we, with layer_idx=layer+1.
- If neuron=cnt[layer+1]-1, next state is FWD_NEXT.
- Otherwise neuron increments and next state is FWD_RD.
REQ-013 FWD_NEXT SHALL clear neuron, then:
- If layer<DEPTH-2: layer increments, next state FWD_RD.
- Else if latched train=1: layer=DEPTH-1, next state BWD_DGEN.
- Otherwise: next state DONE.
REQ-014 Backward states:
- BWD_DGEN asserts d_gen and moves to BWD_DW.
- BWD_DW asserts dw_gen and d_we and moves to BWD_WUPD.
- BWD_WUPD asserts w_we, with layer_idx=layer-1.
- From BWD_WUPD: if neuron=cnt[layer]-1, next state is BWD_PREV; otherwise neuron increments and next state is BWD_DGEN.
REQ-015 BWD_PREV SHALL clear neuron; if layer=1 it moves to DONE, otherwise layer decrements and it moves to BWD_DGEN.
REQ-016 DONE SHALL assert valid for exactly one cycle, increment pass_count (wrapping modulo 2^PASS_W), and return to IDLE.
REQ-017 Strobes SHALL be decoded from registered state only, with at most one strobe high per cycle; layer_idx and neuron_idx SHALL be 0 in IDLE, FWD_NEXT, BWD_PREV and DONE.
REQ-018 While stall=1 in any non-IDLE state, state, counters and pass_count SHALL hold, all strobes and valid SHALL be 0, and indices SHALL hold their current values.
REQ-019 start=1 while busy=1 SHALL be ignored; start and stall high together in IDLE SHALL still be accepted.
REQ-020 Unstalled busy cycles from start acceptance through DONE inclusive:
- Inference: sum over l=1..DEPTH-1 of (2*cnt[l]+1), plus 1.
- Training adds: sum over l=1..DEPTH-1 of (3*cnt[l]+1).
REQ-021 Illegal state encodings SHALL return to IDLE on the next clock.

Reset
REQ-022 RST=1 SHALL, at the next rising edge and regardless of state, force:
- IDLE.
- layer, neuron and pass_count to 0.
- All count entries to NEURONS.
- Latched train and lr_shift to 0.
REQ-023 During reset and in IDLE, every output SHALL be 0.
REQ-024 Reset mid-pass SHALL abort that pass with no valid pulse.

Verification
REQ-025 DEPTH=3, NEURONS=4, counts {4,3,2}, train=0, start pulse:
- busy high for 13 cycles.
- y_we pulses for (layer_idx, neuron_idx) = (1,0), (1,1), (1,2), (2,0), (2,1).
- valid pulses once; pass_count=1.
REQ-026 Same configuration, train=1, lr_shift=3:
- busy high for 30 cycles.
- w_we order is layer_idx 1 neurons 0-1, then layer_idx 0 neurons 0-2.
- learning_rate=3 only in the 5 BWD_DW cycles.
REQ-027 stall held 4 cycles during FWD_WR of the first pass:
- busy high for 17 cycles.
- Strobe sequence identical to REQ-025.
REQ-028 cfg_we while busy, and cfg_count=0 and cfg_count=9 written in IDLE:
- The busy write has no effect.
- Stored counts are 1 and 4.
REQ-029 RST asserted in BWD_DW:
- Next cycle all outputs are 0 and the state is IDLE.
- No valid pulse.
- Subsequent pass_count starts from 0.
REQ-030 pass_count at 2^PASS_W-1 plus one pass wraps to 0.
